// File: rtl/multi_countdown_timer_pkg.sv
// Shared constants, BCD payload type and helpers for the multi-channel countdown timer.
package multi_countdown_timer_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned BCD_W   = 16;

    localparam int unsigned SEC_LSB  = 0;
    localparam int unsigned TSEC_LSB = 4;
    localparam int unsigned MIN_LSB  = 8;
    localparam int unsigned TMIN_LSB = 12;

    localparam logic [3:0] DIGIT_MAX    = 4'd9;
    localparam logic [3:0] TENS_SEC_MAX = 4'd5;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_PAUSED = 2'd2;
    localparam logic [1:0] ST_ALARM  = 2'd3;

    typedef struct packed {
        logic [3:0] tens_min;
        logic [3:0] min;
        logic [3:0] tens_sec;
        logic [3:0] sec;
    } bcd_t;

    function automatic logic [3:0] digit_clamp(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    // Clamp out-of-range digits so the counter never holds a non-BCD value.
    function automatic bcd_t bcd_sanitise(input logic [BCD_W-1:0] raw);
        bcd_t r;
        r.tens_min = digit_clamp(raw[TMIN_LSB +: DIGIT_W], DIGIT_MAX);
        r.min      = digit_clamp(raw[MIN_LSB  +: DIGIT_W], DIGIT_MAX);
        r.tens_sec = digit_clamp(raw[TSEC_LSB +: DIGIT_W], TENS_SEC_MAX);
        r.sec      = digit_clamp(raw[SEC_LSB  +: DIGIT_W], DIGIT_MAX);
        return r;
    endfunction

    // One-second MM:SS decrement with BCD borrow chain.
    function automatic bcd_t bcd_dec(input bcd_t v);
        bcd_t r;
        r = v;
        if (v.sec != 4'd0) begin
            r.sec = v.sec - 4'd1;
        end else begin
            r.sec = DIGIT_MAX;
            if (v.tens_sec != 4'd0) begin
                r.tens_sec = v.tens_sec - 4'd1;
            end else begin
                r.tens_sec = TENS_SEC_MAX;
                if (v.min != 4'd0) begin
                    r.min = v.min - 4'd1;
                end else begin
                    r.min      = DIGIT_MAX;
                    r.tens_min = v.tens_min - 4'd1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/multi_countdown_timer_if.sv
// Control/status bundle between a host and the multi-channel countdown timer.
interface multi_countdown_timer_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned SEL_W  = 2
);
    logic [multi_countdown_timer_pkg::BCD_W-1:0] prog_bcd;
    logic [NUM_CH-1:0] load;
    logic [NUM_CH-1:0] start;
    logic [NUM_CH-1:0] pause;
    logic [NUM_CH-1:0] clear;
    logic [SEL_W-1:0]  disp_sel;
    logic [NUM_CH-1:0] running;
    logic [NUM_CH-1:0] done_pulse;
    logic [NUM_CH-1:0] alarm;
    logic [NUM_CH-1:0] alarm_blink;
    logic [multi_countdown_timer_pkg::BCD_W-1:0] disp_bcd;
    logic disp_running;
    logic disp_alarm;

    modport master (
        output prog_bcd, load, start, pause, clear, disp_sel,
        input  running, done_pulse, alarm, alarm_blink, disp_bcd, disp_running, disp_alarm
    );

    modport slave (
        input  prog_bcd, load, start, pause, clear, disp_sel,
        output running, done_pulse, alarm, alarm_blink, disp_bcd, disp_running, disp_alarm
    );
endinterface

// File: rtl/multi_countdown_timer_timer_channel.sv
// One countdown channel: control FSM, BCD down-counter, load sanitiser and alarm blink.
module timer_channel
    import multi_countdown_timer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic [BCD_W-1:0] prog_bcd,
    input  logic             load,
    input  logic             start,
    input  logic             pause,
    input  logic             clear,
    output bcd_t             value,
    output logic             running,
    output logic             alarm,
    output logic             done_pulse,
    output logic             alarm_blink
);

    logic [1:0] state, state_nx;
    bcd_t       value_nx;
    logic       done_nx, blink_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            value       <= '0;
            done_pulse  <= 1'b0;
            alarm_blink <= 1'b0;
        end else begin
            state       <= state_nx;
            value       <= value_nx;
            done_pulse  <= done_nx;
            alarm_blink <= blink_nx;
        end
    end

    // Effective strobes pre-empt the tick; ignored strobes leave the tick path alone.
    always_comb begin
        state_nx = state;
        value_nx = value;
        done_nx  = 1'b0;
        blink_nx = alarm_blink;
        if (clear) begin
            state_nx = ST_IDLE;
            value_nx = '0;
            blink_nx = 1'b0;
        end else if (load && state != ST_RUN) begin
            state_nx = ST_IDLE;
            value_nx = bcd_sanitise(prog_bcd);
            blink_nx = 1'b0;
        end else if (pause && state == ST_RUN) begin
            state_nx = ST_PAUSED;
        end else if (start && (state == ST_IDLE || state == ST_PAUSED) && value != '0) begin
            state_nx = ST_RUN;
        end else if (tick && state == ST_RUN) begin
            if (value == bcd_t'(16'h0001)) begin
                state_nx = ST_ALARM;
                value_nx = '0;
                done_nx  = 1'b1;
                blink_nx = 1'b0;
            end else begin
                value_nx = bcd_dec(value);
            end
        end else if (tick && state == ST_ALARM) begin
            blink_nx = ~alarm_blink;
        end
    end

    assign running = (state == ST_RUN);
    assign alarm   = (state == ST_ALARM);

endmodule

// File: rtl/multi_countdown_timer.sv
// NUM_CH MM:SS countdown timers on a shared 1 s prescaler with a display-select mux.
module multi_countdown_timer
    import multi_countdown_timer_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned TICK_MAX  = 4999999,
    parameter int unsigned CTR_WIDTH = 23,
    parameter int unsigned SEL_W     = 2
)(
    input  logic                    clk,
    input  logic                    reset,
    multi_countdown_timer_if.slave  bus
);

    logic [CTR_WIDTH-1:0] presc;
    logic                 tick;

    logic [NUM_CH-1:0] ch_running, ch_alarm, ch_done, ch_blink;
    bcd_t              ch_value [NUM_CH];

    // Free-running prescaler; channel controls never restart it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc <= '0;
        end else if (presc == CTR_WIDTH'(TICK_MAX)) begin
            presc <= '0;
        end else begin
            presc <= presc + CTR_WIDTH'(1);
        end
    end

    assign tick = (presc == CTR_WIDTH'(TICK_MAX));

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        timer_channel u_ch (
            .clk         (clk),
            .rst_n       (reset),
            .tick        (tick),
            .prog_bcd    (bus.prog_bcd),
            .load        (bus.load[i]),
            .start       (bus.start[i]),
            .pause       (bus.pause[i]),
            .clear       (bus.clear[i]),
            .value       (ch_value[i]),
            .running     (ch_running[i]),
            .alarm       (ch_alarm[i]),
            .done_pulse  (ch_done[i]),
            .alarm_blink (ch_blink[i])
        );
    end

    assign bus.running     = ch_running;
    assign bus.alarm       = ch_alarm;
    assign bus.done_pulse  = ch_done;
    assign bus.alarm_blink = ch_blink;

    // Unmatched selects (>= NUM_CH) fall through to all-zero display.
    always_comb begin
        bus.disp_bcd     = '0;
        bus.disp_running = 1'b0;
        bus.disp_alarm   = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (bus.disp_sel == SEL_W'(i)) begin
                bus.disp_bcd     = ch_value[i];
                bus.disp_running = ch_running[i];
                bus.disp_alarm   = ch_alarm[i];
            end
        end
    end

endmodule

// File: tb/tb_multi_countdown_timer.sv
// Directed bench for multi_countdown_timer with a 10-cycle tick (TICK_MAX = 9).
module tb_multi_countdown_timer;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   edge_cnt;

    multi_countdown_timer_if #(.NUM_CH(4), .SEL_W(2)) bus ();
    multi_countdown_timer_if #(.NUM_CH(3), .SEL_W(2)) bus3 ();

    multi_countdown_timer #(.NUM_CH(4), .TICK_MAX(9), .CTR_WIDTH(4), .SEL_W(2)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    multi_countdown_timer #(.NUM_CH(3), .TICK_MAX(9), .CTR_WIDTH(4), .SEL_W(2)) dut3 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent edge counter: edge numbers that are multiples of 10 are tick edges.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Park just after the edge preceding a tick edge.
    task automatic to_pre_tick();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while ((edge_cnt % 10) != 9 && n < 40);
    endtask

    task automatic wait_tick();
        to_pre_tick();
        step();
    endtask

    task automatic strobe(input logic [3:0] l, input logic [3:0] s,
                          input logic [3:0] p, input logic [3:0] c);
        bus.load  = l;
        bus.start = s;
        bus.pause = p;
        bus.clear = c;
        step();
        bus.load  = '0;
        bus.start = '0;
        bus.pause = '0;
        bus.clear = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.prog_bcd = '0; bus.load = '0; bus.start = '0; bus.pause = '0; bus.clear = '0;
        bus.disp_sel = 2'd0;
        bus3.prog_bcd = '0; bus3.load = '0; bus3.start = '0; bus3.pause = '0; bus3.clear = '0;
        bus3.disp_sel = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_disp",    32'(bus.disp_bcd), 32'h0);
        check("rst_running", 32'(bus.running), 32'h0);
        check("rst_alarm",   32'(bus.alarm), 32'h0);
        rst_n = 1'b1;

        // Basic countdown to alarm on ch0
        bus.prog_bcd = 16'h0003;
        strobe(4'b0001, 4'b0000, 4'b0000, 4'b0000);
        check("ld0_value", 32'(bus.disp_bcd), 32'h0003);
        check("ld0_idle",  32'(bus.running), 32'h0);
        strobe(4'b0000, 4'b0001, 4'b0000, 4'b0000);
        check("st0_run", 32'(bus.running), 32'h1);
        wait_tick();
        check("cd_0002", 32'(bus.disp_bcd), 32'h0002);
        wait_tick();
        check("cd_0001", 32'(bus.disp_bcd), 32'h0001);
        to_pre_tick();
        check("cd_pre_done",  32'(bus.done_pulse), 32'h0);
        check("cd_pre_alarm", 32'(bus.alarm), 32'h0);
        step();
        check("cd_0000",     32'(bus.disp_bcd), 32'h0000);
        check("cd_done",     32'(bus.done_pulse), 32'h1);
        check("cd_alarm",    32'(bus.alarm), 32'h1);
        check("cd_blink0",   32'(bus.alarm_blink), 32'h0);
        check("cd_disp_alm", 32'(bus.disp_alarm), 32'h1);
        check("cd_run_off",  32'(bus.running), 32'h0);
        step();
        check("cd_done_1cyc", 32'(bus.done_pulse), 32'h0);
        check("cd_alarm_held", 32'(bus.alarm), 32'h1);
        wait_tick();
        check("blink_1", 32'(bus.alarm_blink), 32'h1);
        wait_tick();
        check("blink_2", 32'(bus.alarm_blink), 32'h0);
        wait_tick();
        check("blink_3", 32'(bus.alarm_blink), 32'h1);
        strobe(4'b0000, 4'b0000, 4'b0000, 4'b0001);
        check("clr_alarm", 32'(bus.alarm), 32'h0);
        check("clr_blink", 32'(bus.alarm_blink), 32'h0);
        check("clr_value", 32'(bus.disp_bcd), 32'h0000);

        // Borrow chain on ch1
        bus.disp_sel = 2'd1;
        bus.prog_bcd = 16'h1000;
        strobe(4'b0010, 4'b0000, 4'b0000, 4'b0000);
        strobe(4'b0000, 4'b0010, 4'b0000, 4'b0000);
        wait_tick();
        check("borrow_0959", 32'(bus.disp_bcd), 32'h0959);
        strobe(4'b0000, 4'b0000, 4'b0010, 4'b0000);
        bus.prog_bcd = 16'h0100;
        strobe(4'b0010, 4'b0000, 4'b0000, 4'b0000);
        check("ld_0100", 32'(bus.disp_bcd), 32'h0100);
        strobe(4'b0000, 4'b0010, 4'b0000, 4'b0000);
        wait_tick();
        check("borrow_0059", 32'(bus.disp_bcd), 32'h0059);

        // Load ignored while running, sanitised otherwise
        bus.prog_bcd = 16'hAB7F;
        strobe(4'b0010, 4'b0000, 4'b0000, 4'b0000);
        check("ld_in_run_val", 32'(bus.disp_bcd), 32'h0059);
        check("ld_in_run_run", 32'(bus.disp_running), 32'h1);
        strobe(4'b0000, 4'b0000, 4'b0010, 4'b0000);
        strobe(4'b0010, 4'b0000, 4'b0000, 4'b0000);
        check("sanitise", 32'(bus.disp_bcd), 32'h9959);
        check("sanitise_idle", 32'(bus.disp_running), 32'h0);
        strobe(4'b0000, 4'b0000, 4'b0000, 4'b0010);
        strobe(4'b0000, 4'b0010, 4'b0000, 4'b0000);
        check("start_zero_run", 32'(bus.running), 32'h0);
        check("start_zero_val", 32'(bus.disp_bcd), 32'h0000);

        // Pause colliding with a tick on ch2
        bus.disp_sel = 2'd2;
        bus.prog_bcd = 16'h0011;
        strobe(4'b0100, 4'b0000, 4'b0000, 4'b0000);
        strobe(4'b0000, 4'b0100, 4'b0000, 4'b0000);
        wait_tick();
        check("p_0010", 32'(bus.disp_bcd), 32'h0010);
        to_pre_tick();
        strobe(4'b0000, 4'b0000, 4'b0100, 4'b0000);
        check("p_coll_val", 32'(bus.disp_bcd), 32'h0010);
        check("p_coll_run", 32'(bus.running), 32'h0);
        wait_tick();
        wait_tick();
        wait_tick();
        check("p_hold_val", 32'(bus.disp_bcd), 32'h0010);
        strobe(4'b0000, 4'b0100, 4'b0000, 4'b0000);
        check("resume_run", 32'(bus.running), 32'h4);
        check("resume_val", 32'(bus.disp_bcd), 32'h0010);
        wait_tick();
        check("resume_0009", 32'(bus.disp_bcd), 32'h0009);
        strobe(4'b0000, 4'b0000, 4'b0000, 4'b0100);

        // Parallel channels and display mux
        bus.prog_bcd = 16'h0005;
        strobe(4'b0001, 4'b0000, 4'b0000, 4'b0000);
        bus.prog_bcd = 16'h0002;
        strobe(4'b1000, 4'b0000, 4'b0000, 4'b0000);
        strobe(4'b0000, 4'b1001, 4'b0000, 4'b0000);
        check("par_running", 32'(bus.running), 32'h9);
        wait_tick();
        wait_tick();
        check("par_alarm3", 32'(bus.alarm), 32'h8);
        check("par_done3",  32'(bus.done_pulse), 32'h8);
        bus.disp_sel = 2'd3;
        #1;
        check("mux3_bcd",   32'(bus.disp_bcd), 32'h0000);
        check("mux3_alarm", 32'(bus.disp_alarm), 32'h1);
        check("mux3_run",   32'(bus.disp_running), 32'h0);
        bus.disp_sel = 2'd0;
        #1;
        check("mux0_bcd", 32'(bus.disp_bcd), 32'h0003);
        check("mux0_run", 32'(bus.disp_running), 32'h1);
        wait_tick();
        wait_tick();
        check("par_ch0_0001", 32'(bus.disp_bcd), 32'h0001);
        check("par_ch0_noalm", 32'(bus.alarm), 32'h8);
        to_pre_tick();
        step();
        check("par_alarm_all", 32'(bus.alarm), 32'h9);
        check("par_done0",     32'(bus.done_pulse), 32'h1);

        // Three-channel build: select 3 is out of range
        bus3.prog_bcd = 16'h1234;
        bus3.load = 3'b001;
        step();
        bus3.load = '0;
        check("n3_sel0", 32'(bus3.disp_bcd), 32'h1234);
        bus3.disp_sel = 2'd3;
        #1;
        check("n3_sel3_bcd",  32'(bus3.disp_bcd), 32'h0000);
        check("n3_sel3_flag", 32'({bus3.disp_running, bus3.disp_alarm}), 32'h0);

        // Asynchronous reset mid-cycle with channels in ALARM
        step();
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_alarm", 32'(bus.alarm), 32'h0);
        check("arst_disp",  32'(bus.disp_bcd), 32'h0);
        check("arst_blink", 32'(bus.alarm_blink), 32'h0);
        check("arst_done",  32'(bus.done_pulse), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        step();
        check("post_rst_run", 32'(bus.running), 32'h0);
        check("post_rst_alm", 32'(bus.alarm), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_countdown_timer.md
Name: multi_countdown_timer

Overview:
- NUM_CH independent MM:SS BCD countdown timers sharing one on-chip 1 s prescaler.
- Each channel has load/start/pause/clear controls, a done pulse and a latched alarm with a blink output.
- A channel-select mux presents one channel's digits to the existing quad seven-segment display path.
- Generalises the single fixed kitchen timer to a parametrised multi-channel core with pause/resume and alarm acknowledge.

Parameters:
- NUM_CH, 4, number of independent timer channels (1..8).
- TICK_MAX, 4999999, prescaler terminal count; tick period is TICK_MAX+1 clk cycles (1 s at 5 MHz).
- CTR_WIDTH, 23, prescaler width; must hold TICK_MAX.
- SEL_W, 2, width of disp_sel; must be at least clog2(NUM_CH).

Ports:
- clk, input, 1: single system clock (5 MHz domain).
- reset, input, 1: asynchronous, active-low reset.
- prog_bcd, input, 16: load value {tens_min, min, tens_sec, sec}, 4 bits per digit.
- load, input, NUM_CH: per-channel load strobe, 1 cycle.
- start, input, NUM_CH: per-channel start/resume strobe.
- pause, input, NUM_CH: per-channel pause strobe.
- clear, input, NUM_CH: per-channel clear / alarm-acknowledge strobe.
- disp_sel, input, SEL_W: channel shown on the disp_* outputs.
- running, output, NUM_CH: channel is in RUN.
- done_pulse, output, NUM_CH: 1-cycle pulse on reaching 00:00.
- alarm, output, NUM_CH: channel is in ALARM.
- alarm_blink, output, NUM_CH: toggles on each tick while in ALARM; 0 otherwise.
- disp_bcd, output, 16: selected channel's current value.
- disp_running, output, 1: running[disp_sel].
- disp_alarm, output, 1: alarm[disp_sel].

Behaviour:
- Reset (reset=0, async):
  - Prescaler = 0.
  - All channels in IDLE with value 00:00.
  - All outputs 0.
- Prescaler:
  - Free-running; counts 0..TICK_MAX, then wraps to 0.
  - tick is high for 1 cycle when count == TICK_MAX.
  - Shared by all channels, never restarted by channel controls. The first decrement after start therefore occurs 1..TICK_MAX+1 cycles later.
- Channel FSM states: IDLE, RUN, PAUSED, ALARM.
- Strobe priority within a cycle: clear > load > pause > start.
- clear: any state -> IDLE, value 00:00; alarm_blink forced to 0.
- load:
  - In IDLE, PAUSED or ALARM: -> IDLE, value = sanitised prog_bcd.
  - In RUN: ignored.
- Sanitising prog_bcd:
  - Any digit > 9 clamps to 9.
  - tens_sec > 5 clamps to 5.
  - tens_min accepts 0..9 (max 99:59).
- start:
  - IDLE or PAUSED with value != 00:00 -> RUN.
  - Value == 00:00: ignored.
  - RUN or ALARM: ignored.
- pause: RUN -> PAUSED; value held. Ignored in all other states.
- Decrement (RUN and tick):
  - value -= 1 s in BCD.
  - sec wraps 0 -> 9 with borrow; tens_sec 0 -> 5 with borrow; min 0 -> 9 with borrow into tens_min.
  - Registered: new value is visible the cycle after tick.
- Expiry: when RUN and tick and value == 00:01:
  - value -> 00:00 and state -> ALARM, both in the same update.
  - done_pulse asserts for exactly that one cycle, aligned with the first cycle alarm=1.
- ALARM: held until clear or load. alarm_blink starts at 0 and toggles on every tick.
- Simultaneous strobe and tick on the same cycle: the strobe wins and no decrement occurs. Example: pause with tick -> PAUSED, value unchanged.
- Channels are fully independent; identical strobes on several channels act in parallel.
- disp_* outputs are combinational from disp_sel. disp_sel >= NUM_CH drives disp_bcd = 0 and flags = 0.

Decomposition:
- Shared include file with:
  - FSM state localparams (IDLE=2'd0, RUN=2'd1, PAUSED=2'd2, ALARM=2'd3).
  - BCD constants: DIGIT_MAX=4'd9, TENS_SEC_MAX=4'd5.
  - Digit field offsets within prog_bcd/disp_bcd.
- One sub-module, timer_channel: FSM, 4-digit BCD down-counter, sanitiser and blink flop.
  - Instantiated NUM_CH times via generate.
  - Top level holds the prescaler and the display mux.

Test Plan (TICK_MAX=9, i.e. tick every 10 clk):
- Reset: hold reset=0 mid-count, then release -> all channels IDLE, disp_bcd=0x0000, running=0, alarm=0 within 0 cycles of reset assertion.
- Countdown: ch0 load 0x0003 then start -> 00:02, 00:01, 00:00 on successive ticks; done_pulse[0] is exactly 1 cycle, coincident with alarm[0] rising; alarm_blink[0] toggles on each later tick; clear[0] -> IDLE, 0x0000.
- Borrow chain: ch1 load 0x1000 and run 1 tick -> 0x0959. Load 0x0100 and run 1 tick -> 0x0059.
- Sanitise and ignore rules:
  - Load 0xAB7F -> value 0x9959.
  - start with value 0x0000 -> stays IDLE.
  - load during RUN -> value unaffected.
- Pause/resume and collision:
  - ch2 running at 0x0010, pause asserted on a tick cycle -> stays 0x0010, PAUSED, no decrement across 3 ticks.
  - start -> resumes at 0x0009 after the next tick.
- Independence and mux: ch0 and ch3 started with 0x0005 and 0x0002 on the same cycle -> ch3 alarms 3 ticks before ch0. disp_sel=3 shows ch3 value and disp_alarm; disp_sel=NUM_CH with NUM_CH=3 config -> zeros.
